mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-core arbiter for the shared data-memory port.
- Replaces the fixed per-core stall constants in the dual-core top with real round-robin arbitration of read and write requests onto one memory port.
- Routes returned read data back to the issuing core through a latency-matched tag pipeline.
- Aggregates per-core halt into a sticky system halt.
- Sits between the cores' data ports and the data-read/write port of mem; instruction fetch ports are untouched.

Parameters:
- NCORES, 2, number of cores (2..8).
- AW, 15, word-address width.
- DW, 16, data width.
- MEM_LAT, 1, memory read latency in cycles (1..4).
- CW, 16, per-core stall-counter width.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- core_rd_req  in  NCORES  per-core read request, held until granted
- core_wr_req  in  NCORES  per-core write request, held until granted
- core_addr  in  NCORES*AW  per-core word address, core i at [i*AW +: AW]
- core_wdata  in  NCORES*DW  per-core write data
- core_grant  out  NCORES  one-hot or zero; the op issued this cycle
- core_stall  out  NCORES  request pending and not granted this cycle
- core_rvalid  out  NCORES  one-hot read-data-valid
- core_rdata  out  DW  read data, broadcast to all cores
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_ren
- core_halt  in  NCORES  per-core halt
- all_halt  out  1  sticky; all cores halted
- stall_cnt  out  NCORES*CW  per-core saturating count of stall cycles

Behaviour:
- Reset (async assert, sync-style release):
  - core_grant, core_rvalid, mem_ren, mem_wen, all_halt, stall_cnt = 0.
  - mem_addr, mem_wdata, core_rdata = 0.
  - rr pointer = 0; tag pipeline cleared.
- Request: req[i] = core_rd_req[i] | core_wr_req[i].
- Arbitration is combinational in the same cycle. Search starts at index ptr, ascending and wrapping; the first set req[i] wins. At most one grant per cycle.
- ptr update on any grant: ptr <= (winner+1) mod NCORES. No grant: ptr unchanged.
- Fairness: any held request is granted within NCORES cycles (at most NCORES-1 stall cycles).
- Winner with wr_req: write issues. mem_wen=1, mem_addr and mem_wdata from that core, mem_ren=0.
- Winner with both rd and wr: write issues first. The core drops wr_req next cycle and keeps rd_req.
- Winner with rd only: mem_ren=1, mem_addr from that core. A tag {valid, core index} enters the MEM_LAT-deep shift register.
- Read return: when the tag at stage MEM_LAT is valid, core_rvalid[idx]=1 and core_rdata=mem_rdata, both combinational from the tag and mem_rdata. Exactly MEM_LAT cycles after the issue cycle.
- Tag pipeline advances every cycle. Back-to-back reads from different cores return in issue order, one per cycle.
- Read and write to the same address are serialised by grant order. Read-after-write from any core sees the new data (the memory port is single).
- core_stall[i] = req[i] & ~core_grant[i].
- stall_cnt[i] increments when core_stall[i]=1 and saturates at 2^CW-1. Never cleared except by reset.
- all_halt: set on the clock edge where &core_halt==1 and held until reset. Later deassertion of core_halt bits does not clear it.
- Reset mid-read: in-flight tags are discarded and no core_rvalid pulse occurs after reset release.
- Invariant: mem_ren & mem_wen is never 1.

Decomposition:
- Shared package mem_arb_pkg: core-index width localparam (clog2 of NCORES, min 1), tag struct {valid, idx}, MAX_CORES=8.
- One sub-module, rr_arbiter: request vector + ptr -> one-hot grant + winner index, purely combinational. It is reused later for instruction-fetch arbitration.
- Tag pipeline and counters stay in the top.

Test Plan:
- NCORES=2, MEM_LAT=1. Core0 and core1 both read continuously from reset -> grants alternate 0,1,0,1. Each core_stall is high every other cycle. After 10 cycles, stall_cnt = {5,5} ±1 per the pointer start.
- Core1 writes 0xBEEF to addr 0x100, then core0 reads 0x100 the next cycle -> core0 rvalid one cycle after its grant, rdata = 0xBEEF.
- NCORES=4, MEM_LAT=3. All four cores issue one read each in the same cycle -> grants in order 0,1,2,3 over 4 cycles. rvalid pulses 3 cycles after each grant with the correct per-core data. mem_ren and mem_wen are never both high.
- Core0 asserts rd+wr to addr 5 (wdata 0x1234) -> write granted first, read granted in a later cycle, returned rdata = 0x1234.
- Assert rst_n=0 while two reads are in flight (MEM_LAT=3) -> all outputs 0 immediately and no rvalid after release. First post-reset grant goes to core0 when all cores request.
- core_halt goes 01 -> 11 -> 10 -> all_halt rises on the edge after 11 and stays 1 through 10.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter and its round-robin core.
//   MAX_CORES  : largest supported core count
//   MAX_IDX_W  : index width able to name any of MAX_CORES cores
//   idx_width  : index width for a given core count (never below 1 bit)
//   arb_tag_t  : read-return tag {valid, issuing core index}
package mem_arb_pkg;

  localparam int MAX_CORES = 8;
  localparam int MAX_IDX_W = $clog2(MAX_CORES);

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } arb_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector, one bit per requester
//   ptr    : index where the search starts (ascending, wrapping)
//   grant  : one-hot grant, zero when nothing requests
//   winner : index of the granted requester (0 when found = 0)
//   found  : some requester was granted
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [IW-1:0] cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        winner      = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter placing N cores' data reads/writes onto one memory port.
// Read data is routed back to the issuing core by a MEM_LAT-deep tag pipeline.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   core_rd_req / core_wr_req  : per-core requests, held until granted
//   core_addr / core_wdata     : per-core address / write data (packed, core i at [i*W +: W])
//   core_grant                 : one-hot op issued this cycle
//   core_stall                 : request pending but not granted this cycle
//   core_rvalid / core_rdata   : one-hot read return, data broadcast to all cores
//   mem_ren/mem_wen/mem_addr/mem_wdata/mem_rdata : single memory port
//   core_halt / all_halt       : per-core halt, sticky all-halted flag
//   stall_cnt                  : per-core saturating stall-cycle counters
//
// Handshake: a core raises rd_req and/or wr_req with addr/wdata and holds them
// until it sees core_grant[i] in the same cycle; the grant cycle is the transfer
// cycle. A core with both requests is granted the write first and drops wr_req
// the following cycle, keeping rd_req for a later grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int AW      = 15,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1,
  parameter int CW      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    core_rd_req,
  input  logic [NCORES-1:0]    core_wr_req,
  input  logic [NCORES*AW-1:0] core_addr,
  input  logic [NCORES*DW-1:0] core_wdata,
  output logic [NCORES-1:0]    core_grant,
  output logic [NCORES-1:0]    core_stall,
  output logic [NCORES-1:0]    core_rvalid,
  output logic [DW-1:0]        core_rdata,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic [NCORES-1:0]    core_halt,
  output logic                 all_halt,
  output logic [NCORES*CW-1:0] stall_cnt
);

  localparam int IW = idx_width(NCORES);

  logic [NCORES-1:0] req;
  logic [NCORES-1:0] grant;
  logic [IW-1:0]     winner;
  logic              found;
  logic [IW-1:0]     ptr_q;
  logic              win_wr;
  arb_tag_t          new_tag;
  arb_tag_t          ret_tag;
  arb_tag_t          tag_q [MEM_LAT];
  logic [CW-1:0]     cnt_q [NCORES];
  logic              all_halt_q;

  // Requests are masked while reset is asserted so every combinational
  // output (grant, mem port, stall) reads zero during reset.
  assign req = (core_rd_req | core_wr_req) & {NCORES{rst_n}};

  rr_arbiter #(
    .N  (NCORES),
    .IW (IW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .grant  (grant),
    .winner (winner),
    .found  (found)
  );

  assign win_wr     = core_wr_req[winner];
  assign core_grant = grant;
  assign core_stall = req & ~grant;
  assign mem_wen    = found & win_wr;
  assign mem_ren    = found & ~win_wr;
  assign mem_addr   = found ? core_addr[int'(winner)*AW +: AW] : '0;
  assign mem_wdata  = mem_wen ? core_wdata[int'(winner)*DW +: DW] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (int'(winner) == NCORES - 1) ? '0 : winner + 1'b1;
    end
  end

  // Tag for the read issued this cycle; it reaches the last stage exactly
  // when the memory presents the matching data.
  always_comb begin
    new_tag       = '0;
    new_tag.valid = mem_ren;
    new_tag.idx   = MAX_IDX_W'(winner);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MEM_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= new_tag;
      for (int s = 1; s < MEM_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign ret_tag    = tag_q[MEM_LAT-1];
  assign core_rdata = ret_tag.valid ? mem_rdata : '0;

  always_comb begin
    core_rvalid = '0;
    for (int i = 0; i < NCORES; i++) begin
      core_rvalid[i] = ret_tag.valid && (ret_tag.idx == MAX_IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NCORES; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (core_stall[g] && (cnt_q[g] != {CW{1'b1}})) begin
        cnt_q[g] <= cnt_q[g] + 1'b1;
      end
    end
    assign stall_cnt[g*CW +: CW] = cnt_q[g];
  end

  // Sticky: once every core has halted the flag stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_halt_q <= 1'b0;
    end else if (&core_halt) begin
      all_halt_q <= 1'b1;
    end
  end

  assign all_halt = all_halt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int NCORES  = 4;
  localparam int AW      = 15;
  localparam int DW      = 16;
  localparam int MEM_LAT = 3;
  localparam int CW      = 4;
  localparam int IW      = 2;
  localparam int EW      = 32 + IW + DW;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NCORES-1:0]    core_rd_req;
  logic [NCORES-1:0]    core_wr_req;
  logic [NCORES*AW-1:0] core_addr;
  logic [NCORES*DW-1:0] core_wdata;
  logic [NCORES-1:0]    core_grant;
  logic [NCORES-1:0]    core_stall;
  logic [NCORES-1:0]    core_rvalid;
  logic [DW-1:0]        core_rdata;
  logic                 mem_ren;
  logic                 mem_wen;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;
  logic [NCORES-1:0]    core_halt;
  logic                 all_halt;
  logic [NCORES*CW-1:0] stall_cnt;

  mem_port_arbiter #(
    .NCORES  (NCORES),
    .AW      (AW),
    .DW      (DW),
    .MEM_LAT (MEM_LAT),
    .CW      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_rd_req (core_rd_req),
    .core_wr_req (core_wr_req),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_grant  (core_grant),
    .core_stall  (core_stall),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .core_halt   (core_halt),
    .all_halt    (all_halt),
    .stall_cnt   (stall_cnt)
  );

  // ---------------- memory with MEM_LAT read latency ----------------
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [MEM_LAT];
  logic          mem_init_done = 1'b0;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 7 + 16'h0123);
  endfunction

  assign mem_rdata = rd_pipe[MEM_LAT-1];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1 << AW); i++) mem_arr[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_wen) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem_arr[mem_addr];
    for (int s = 1; s < MEM_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end

  // ---------------- scoreboard / reference model ----------------
  int                n_checks = 0;
  int                n_err    = 0;
  int                cyc      = 0;
  int                m_ptr    = 0;
  int                m_cnt [NCORES];
  bit                m_halt   = 1'b0;
  logic [DW-1:0]     exp_mem [0:(1<<AW)-1];
  logic [EW-1:0]     exp_q[$];
  logic [DW-1:0]     last_rdata [NCORES];
  logic [NCORES-1:0] dut_grant_q = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Runs once per cycle at the falling edge: predicts this cycle's outputs
  // from the driven inputs and the model state, then advances the model.
  task automatic check_cycle();
    logic [NCORES-1:0] req;
    logic [NCORES-1:0] eg;
    logic [NCORES-1:0] erv;
    logic [AW-1:0]     a;
    logic [DW-1:0]     wd;
    logic [EW-1:0]     ent;
    int                ew;
    int                j;
    cyc++;
    if (!rst_n) begin
      check("rst_grant",  core_grant,  '0);
      check("rst_rvalid", core_rvalid, '0);
      check("rst_rdata",  core_rdata,  '0);
      check("rst_ren",    mem_ren,     '0);
      check("rst_wen",    mem_wen,     '0);
      check("rst_addr",   mem_addr,    '0);
      check("rst_wdata",  mem_wdata,   '0);
      check("rst_halt",   all_halt,    '0);
      check("rst_cnt",    stall_cnt,   '0);
      m_ptr  = 0;
      m_halt = 1'b0;
      for (int i = 0; i < NCORES; i++) m_cnt[i] = 0;
      exp_q.delete();
      dut_grant_q = '0;
      return;
    end
    req = core_rd_req | core_wr_req;
    eg  = '0;
    ew  = -1;
    for (int k = 0; k < NCORES; k++) begin
      j = (m_ptr + k) % NCORES;
      if (ew < 0 && req[j]) ew = j;
    end
    if (ew >= 0) eg[ew] = 1'b1;
    check("grant", core_grant, eg);
    check("stall", core_stall, req & ~eg);
    check("ren_wen_excl", mem_ren & mem_wen, 1'b0);
    if (ew >= 0) begin
      a  = core_addr[ew*AW +: AW];
      wd = core_wdata[ew*DW +: DW];
      check("mem_wen", mem_wen, core_wr_req[ew]);
      check("mem_ren", mem_ren, !core_wr_req[ew]);
      check("mem_addr", mem_addr, a);
      if (core_wr_req[ew]) begin
        check("mem_wdata", mem_wdata, wd);
        exp_mem[a] = wd;
      end else begin
        exp_q.push_back({32'(cyc + MEM_LAT), IW'(ew), exp_mem[a]});
      end
      m_ptr = (ew + 1) % NCORES;
    end else begin
      check("idle_ren", mem_ren, 1'b0);
      check("idle_wen", mem_wen, 1'b0);
    end
    for (int i = 0; i < NCORES; i++) begin
      check($sformatf("stall_cnt%0d", i), stall_cnt[i*CW +: CW], m_cnt[i]);
      if (req[i] && !eg[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
    end
    if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
      ent = exp_q.pop_front();
      erv = '0;
      erv[ent[DW +: IW]] = 1'b1;
      check("rvalid", core_rvalid, erv);
      check("rdata", core_rdata, ent[DW-1:0]);
    end else begin
      check("rvalid_idle", core_rvalid, '0);
    end
    for (int i = 0; i < NCORES; i++) if (core_rvalid[i]) last_rdata[i] = core_rdata;
    check("all_halt", all_halt, m_halt);
    if (&core_halt) m_halt = 1'b1;
    dut_grant_q = core_grant;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: check at the falling edge, then after the rising edge
  // retire whatever the DUT granted (write first for rd+wr requesters).
  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCORES; i++) begin
      if (dut_grant_q[i]) begin
        if (core_wr_req[i]) core_wr_req[i] = 1'b0;
        else                core_rd_req[i] = 1'b0;
      end
    end
  endtask

  function automatic bit idle(input int c);
    return !core_rd_req[c] && !core_wr_req[c];
  endfunction

  task automatic issue(input int c, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_addr[c*AW +: AW]  = a;
    core_wdata[c*DW +: DW] = d;
    core_rd_req[c]         = rd;
    core_wr_req[c]         = wr;
  endtask

  task automatic drain();
    int n = 0;
    while ((|core_rd_req || |core_wr_req) && n < 40) begin
      cycle();
      n++;
    end
    check("drain_timeout", (|core_rd_req) || (|core_wr_req), 1'b0);
    repeat (MEM_LAT + 1) cycle();
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    rst_n       = 1'b1;
    core_rd_req = '0;
    core_wr_req = '0;
    core_addr   = '0;
    core_wdata  = '0;
    core_halt   = '0;
    for (int i = 0; i < (1 << AW); i++) exp_mem[i] = init_val(i);
    for (int i = 0; i < NCORES; i++) begin
      m_cnt[i]      = 0;
      last_rdata[i] = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;

    // Two cores reading continuously: grants alternate, one stall per cycle.
    repeat (10) begin
      for (int c = 0; c < 2; c++)
        if (idle(c)) issue(c, 1'b1, 1'b0, AW'($urandom_range(0, 255)), '0);
      cycle();
    end
    check("alt_stall0", stall_cnt[0*CW +: CW], 5);
    check("alt_stall1", stall_cnt[1*CW +: CW], 5);
    drain();

    // Write then read-after-write from another core.
    last_rdata[0] = '0;
    issue(1, 1'b0, 1'b1, 15'h100, 16'hBEEF);
    cycle();
    issue(0, 1'b1, 1'b0, 15'h100, '0);
    cycle();
    drain();
    check("raw_rdata", last_rdata[0], 16'hBEEF);

    // Reset with two reads in flight, then all four cores read.
    issue(2, 1'b1, 1'b0, 15'h020, '0);
    issue(3, 1'b1, 1'b0, 15'h030, '0);
    cycle();
    cycle();
    rst_n = 1'b0;
    for (int c = 0; c < NCORES; c++) issue(c, 1'b1, 1'b0, AW'(16'h200 + c * 3), '0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("post_rst_grant", dut_grant_q, 4'b0001);
    drain();

    // Same core read+write: write first, read returns the new data.
    last_rdata[0] = '0;
    issue(0, 1'b1, 1'b1, 15'h005, 16'h1234);
    cycle();
    check("rdwr_first_is_write", core_wr_req[0], 1'b0);
    drain();
    check("rdwr_rdata", last_rdata[0], 16'h1234);

    // Random traffic on a small address window to create hazards.
    repeat (150) begin
      for (int c = 0; c < NCORES; c++) begin
        if (idle(c) && $urandom_range(0, 99) < 45) begin
          r = $urandom_range(0, 2);
          issue(c, r != 1, r != 0, AW'($urandom_range(0, 15)), DW'($urandom));
        end
      end
      cycle();
    end
    drain();

    // Everyone requesting continuously drives the counters into saturation.
    repeat (60) begin
      for (int c = 0; c < NCORES; c++)
        if (idle(c)) issue(c, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
      cycle();
    end
    drain();
    for (int c = 0; c < NCORES; c++) check($sformatf("sat%0d", c), stall_cnt[c*CW +: CW], CNT_MAX);

    // Halt aggregation: partial, full, then partial again (sticky).
    core_halt = 4'b0001;
    cycle();
    check("halt_partial", all_halt, 1'b0);
    core_halt = 4'b1111;
    cycle();
    core_halt = 4'b1110;
    cycle();
    check("halt_set", all_halt, 1'b1);
    cycle();
    check("halt_sticky", all_halt, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
